// File: rtl/monitor_event_scheduler.sv
// monitor_event_scheduler: buffers input events in a small FIFO, raises periodic
// deadline ticks from a free-running counter, and issues one evaluation at a
// time to the downstream stream monitor, pulsing eval_done when its outputs are valid.
module monitor_event_scheduler #(
  parameter int DATA_W        = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int PERIOD_CYCLES = 5000,
  parameter int PIPE_LAT      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DATA_W-1:0]             x,
  input  logic                          new_x,
  output logic [DATA_W-1:0]             mon_x,
  output logic                          mon_new_x,
  output logic                          mon_tick,
  output logic                          mon_en,
  output logic                          eval_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          missed_deadline
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int LAT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                tick_pending_q, tick_pending_d;
  logic [DATA_W-1:0]   mon_x_q, mon_x_d;
  logic                mon_new_x_q, mon_new_x_d;
  logic                mon_tick_q, mon_tick_d;
  logic                overflow_q, overflow_d;
  logic                missed_q, missed_d;

  logic fifo_nonempty, fifo_full, wrap, lat_last, work_pending;
  logic do_push, do_pop, push_ok, start_issue, consume_tick;

  assign fifo_nonempty = (level_q != '0);
  assign fifo_full     = (level_q == LVL_W'(FIFO_DEPTH));
  assign wrap          = (cnt_q == CNT_W'(PERIOD_CYCLES - 1));
  assign lat_last      = (lat_q == LAT_W'(PIPE_LAT - 1));
  assign work_pending  = fifo_nonempty | tick_pending_q;
  // The event captured at issue is popped at the end of the ISSUE cycle.
  assign do_pop        = en && (state_q == ISSUE) && mon_new_x_q;
  assign do_push       = en && new_x;
  assign push_ok       = do_push && (!fifo_full || do_pop);
  // Issue fields are loaded on the edge that enters ISSUE so they are valid with mon_en.
  assign start_issue   = en && (state_d == ISSUE) && (state_q != ISSUE);
  // Only a tick actually captured by this issue is consumed; a tick raised on the
  // entry edge itself stays pending for the next evaluation.
  assign consume_tick  = (state_q == ISSUE) && mon_tick_q;

  // State and datapath registers, asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      cnt_q          <= '0;
      lat_q          <= '0;
      tick_pending_q <= 1'b0;
      mon_x_q        <= '0;
      mon_new_x_q    <= 1'b0;
      mon_tick_q     <= 1'b0;
      overflow_q     <= 1'b0;
      missed_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      cnt_q          <= cnt_d;
      lat_q          <= lat_d;
      tick_pending_q <= tick_pending_d;
      mon_x_q        <= mon_x_d;
      mon_new_x_q    <= mon_new_x_d;
      mon_tick_q     <= mon_tick_d;
      overflow_q     <= overflow_d;
      missed_q       <= missed_d;
    end
  end

  // Event buffer storage; cleared on reset so discarded events cannot reappear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= x;
    end
  end

  // Next-state logic; the last WAIT cycle chains straight into ISSUE when work is queued.
  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        IDLE:    if (work_pending) state_d = ISSUE;
        ISSUE:   state_d = WAIT;
        WAIT:    if (lat_last) state_d = work_pending ? ISSUE : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next values: FIFO, period counter, tick bookkeeping, latency counter, issue fields.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    level_d        = level_q;
    cnt_d          = cnt_q;
    lat_d          = lat_q;
    tick_pending_d = tick_pending_q;
    mon_x_d        = mon_x_q;
    mon_new_x_d    = mon_new_x_q;
    mon_tick_d     = mon_tick_q;
    overflow_d     = overflow_q;
    missed_d       = missed_q;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      if (wrap) begin
        if (tick_pending_q && !consume_tick) missed_d = 1'b1;
        tick_pending_d = 1'b1;
      end else if (consume_tick) begin
        tick_pending_d = 1'b0;
      end
      if (do_push && fifo_full && !do_pop) overflow_d = 1'b1;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      lat_d = ((state_q == WAIT) && !lat_last) ? lat_q + LAT_W'(1) : '0;
      if (start_issue) begin
        mon_new_x_d = fifo_nonempty;
        mon_tick_d  = tick_pending_q;
        if (fifo_nonempty) mon_x_d = mem_q[rd_ptr_q];
      end
    end
  end

  // Outputs: registered state, with the two strobes gated by en.
  always_comb begin
    mon_en          = en && (state_q == ISSUE);
    eval_done       = en && (state_q == WAIT) && lat_last;
    busy            = (state_q != IDLE);
    mon_x           = mon_x_q;
    mon_new_x       = mon_new_x_q;
    mon_tick        = mon_tick_q;
    fifo_level      = level_q;
    overflow        = overflow_q;
    missed_deadline = missed_q;
  end

endmodule

// File: tb/tb_monitor_event_scheduler.sv
// Directed bench for monitor_event_scheduler: per-cycle vector table for the
// single-event and burst cases, plus hand-written merge, freeze, reset and
// missed-deadline sequences.
`timescale 1ns/1ps
module tb_monitor_event_scheduler;

  logic        clk = 1'b0;
  logic        rst, en, new_x;
  logic [31:0] x;
  logic [31:0] mon_x;
  logic        mon_new_x, mon_tick, mon_en, eval_done, busy, overflow, missed_deadline;
  logic [2:0]  fifo_level;

  logic        rst2, en2, new_x2;
  logic [31:0] x2;
  logic [31:0] mon_x2;
  logic        mon_new_x2, mon_tick2, mon_en2, eval_done2, busy2, overflow2, missed2;
  logic [2:0]  fifo_level2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  monitor_event_scheduler #(.DATA_W(32), .FIFO_DEPTH(4), .PERIOD_CYCLES(20), .PIPE_LAT(3)) dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .new_x(new_x),
    .mon_x(mon_x), .mon_new_x(mon_new_x), .mon_tick(mon_tick), .mon_en(mon_en),
    .eval_done(eval_done), .busy(busy), .fifo_level(fifo_level),
    .overflow(overflow), .missed_deadline(missed_deadline));

  monitor_event_scheduler #(.DATA_W(32), .FIFO_DEPTH(4), .PERIOD_CYCLES(20), .PIPE_LAT(30)) dut_long (
    .clk(clk), .rst(rst2), .en(en2), .x(x2), .new_x(new_x2),
    .mon_x(mon_x2), .mon_new_x(mon_new_x2), .mon_tick(mon_tick2), .mon_en(mon_en2),
    .eval_done(eval_done2), .busy(busy2), .fifo_level(fifo_level2),
    .overflow(overflow2), .missed_deadline(missed2));

  typedef struct {
    logic        do_rst;
    logic        en;
    logic        nx;
    logic [31:0] x;
    logic        men, ed, bsy;
    logic [31:0] mx;
    logic        mnx, mt;
    logic [2:0]  lvl;
    logic        ovf, miss;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic nx, input logic [31:0] xv,
                     input logic men, input logic ed, input logic bsy, input logic [31:0] mx,
                     input logic mnx, input logic mt, input logic [2:0] lvl,
                     input logic ovf, input logic miss);
    vec_t v;
    v.do_rst = r; v.en = e; v.nx = nx; v.x = xv;
    v.men = men; v.ed = ed; v.bsy = bsy; v.mx = mx; v.mnx = mnx; v.mt = mt;
    v.lvl = lvl; v.ovf = ovf; v.miss = miss;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [41:0] snap();
    return {mon_en, eval_done, busy, mon_x, mon_new_x, mon_tick, fifo_level, overflow, missed_deadline};
  endfunction

  // Hold reset across two edges, release on a falling edge so the next rising edge is edge 1.
  task automatic do_reset();
    rst = 1'b0; en = 1'b0; new_x = 1'b0; x = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input logic e, input logic nx, input logic [31:0] xv);
    en = e; new_x = nx; x = xv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_en, n_done, done_edge, bad;
    rst = 1'b0; en = 1'b1; new_x = 1'b1; x = 32'd5;
    rst2 = 1'b0; en2 = 1'b1; new_x2 = 1'b0; x2 = '0;

    // Reset state with en/new_x active: nothing may be captured.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {22'd0, snap()}, 64'd0);

    // Single event: edges 1..6 after reset.
    add(1,1,1,1, 0,0,0,0,0,0,1,0,0);
    add(0,1,0,0, 1,0,1,1,1,0,1,0,0);
    add(0,1,0,0, 0,0,1,1,1,0,0,0,0);
    add(0,1,0,0, 0,0,1,1,1,0,0,0,0);
    add(0,1,0,0, 0,1,1,1,1,0,0,0,0);
    add(0,1,0,0, 0,0,0,1,1,0,0,0,0);
    // Burst of six events x=1..6; 6 is dropped, issues every 4 cycles, tick after wrap at edge 20.
    add(1,1,1,1, 0,0,0,0,0,0,1,0,0);
    add(0,1,1,2, 1,0,1,1,1,0,2,0,0);
    add(0,1,1,3, 0,0,1,1,1,0,2,0,0);
    add(0,1,1,4, 0,0,1,1,1,0,3,0,0);
    add(0,1,1,5, 0,1,1,1,1,0,4,0,0);
    add(0,1,1,6, 1,0,1,2,1,0,4,1,0);
    add(0,1,0,0, 0,0,1,2,1,0,3,1,0);
    add(0,1,0,0, 0,0,1,2,1,0,3,1,0);
    add(0,1,0,0, 0,1,1,2,1,0,3,1,0);
    add(0,1,0,0, 1,0,1,3,1,0,3,1,0);
    add(0,1,0,0, 0,0,1,3,1,0,2,1,0);
    add(0,1,0,0, 0,0,1,3,1,0,2,1,0);
    add(0,1,0,0, 0,1,1,3,1,0,2,1,0);
    add(0,1,0,0, 1,0,1,4,1,0,2,1,0);
    add(0,1,0,0, 0,0,1,4,1,0,1,1,0);
    add(0,1,0,0, 0,0,1,4,1,0,1,1,0);
    add(0,1,0,0, 0,1,1,4,1,0,1,1,0);
    add(0,1,0,0, 1,0,1,5,1,0,1,1,0);
    add(0,1,0,0, 0,0,1,5,1,0,0,1,0);
    add(0,1,0,0, 0,0,1,5,1,0,0,1,0);
    add(0,1,0,0, 0,1,1,5,1,0,0,1,0);
    add(0,1,0,0, 1,0,1,5,0,1,0,1,0);
    add(0,1,0,0, 0,0,1,5,0,1,0,1,0);
    add(0,1,0,0, 0,0,1,5,0,1,0,1,0);
    add(0,1,0,0, 0,1,1,5,0,1,0,1,0);
    add(0,1,0,0, 0,0,0,5,0,1,0,1,0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) do_reset();
      step(vecs[i].en, vecs[i].nx, vecs[i].x);
      chk($sformatf("vec%0d", i), {22'd0, snap()},
          {22'd0, vecs[i].men, vecs[i].ed, vecs[i].bsy, vecs[i].mx, vecs[i].mnx,
           vecs[i].mt, vecs[i].lvl, vecs[i].ovf, vecs[i].miss});
      $display("vec %0d: mon_en=%0b eval_done=%0b busy=%0b mon_x=%0d lvl=%0d ovf=%0b",
               i, mon_en, eval_done, busy, mon_x, fifo_level, overflow);
    end

    // Merge: event arriving on the wrap edge (20) gives one combined evaluation.
    do_reset();
    bad = 0;
    for (int k = 1; k <= 19; k++) begin
      step(1, 0, 0);
      if (busy) bad++;
    end
    chk("merge_idle_before_wrap", 64'(bad), 64'd0);
    step(1, 1, 32'd7);
    step(1, 0, 0);
    chk("merge_issue", {28'd0, mon_en, mon_new_x, mon_tick, mon_x}, {28'd0, 1'b1, 1'b1, 1'b1, 32'd7});
    n_en = 0; n_done = 0; done_edge = 0;
    for (int k = 22; k <= 38; k++) begin
      step(1, 0, 0);
      if (mon_en) n_en++;
      if (eval_done) begin n_done++; done_edge = k; end
    end
    chk("merge_extra_issue", 64'(n_en), 64'd0);
    chk("merge_done_count", 64'(n_done), 64'd1);
    chk("merge_done_edge", 64'(done_edge), 64'd24);
    $display("merge: issues_after=%0d done=%0d at edge %0d", n_en, n_done, done_edge);

    // Enable freeze: en low for edges 5..14 while in WAIT; done moves from edge 5 to 15.
    do_reset();
    step(1, 1, 32'd9);
    step(1, 0, 0);
    chk("freeze_issue", {31'd0, mon_en, mon_x}, {31'd0, 1'b1, 32'd9});
    step(1, 0, 0);
    step(1, 0, 0);
    bad = 0;
    for (int k = 5; k <= 14; k++) begin
      step(0, k[0], 32'h55);
      if (eval_done || mon_en || fifo_level != 3'd0 || !busy) bad++;
    end
    chk("freeze_hold", 64'(bad), 64'd0);
    step(1, 0, 0);
    chk("freeze_done_delayed", 64'(eval_done), 64'd1);
    en = 1'b0;
    #1;
    chk("eval_done_gated", 64'(eval_done), 64'd0);
    en = 1'b1;
    bad = 0;
    for (int k = 16; k <= 30; k++) begin
      step(1, 0, 0);
      if (mon_en || busy) bad++;
    end
    chk("freeze_no_early_issue", 64'(bad), 64'd0);
    step(1, 0, 0);
    chk("freeze_tick_issue", {29'd0, mon_en, mon_new_x, mon_tick, mon_x},
        {29'd0, 1'b1, 1'b0, 1'b1, 32'd9});
    $display("freeze: tick issue at edge 31 mon_new_x=%0b mon_tick=%0b", mon_new_x, mon_tick);

    // Reset mid-WAIT with two events still buffered.
    do_reset();
    step(1, 1, 32'd1);
    step(1, 1, 32'd2);
    step(1, 1, 32'd3);
    step(1, 0, 0);
    chk("pre_reset_wait", {60'd0, busy, fifo_level}, {60'd0, 1'b1, 3'd2});
    rst = 1'b0;
    #1;
    chk("mid_wait_reset", {22'd0, snap()}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1, 0, 0);
      if (mon_en || busy || fifo_level != 3'd0) bad++;
    end
    chk("post_reset_quiet", 64'(bad), 64'd0);
    step(1, 0, 0);
    chk("post_reset_first_tick", {61'd0, mon_en, mon_new_x, mon_tick}, {61'd0, 1'b1, 1'b0, 1'b1});
    $display("reset: quiet until wrap, tick issue mon_en=%0b", mon_en);

    // Missed deadline on the PIPE_LAT=30 build: issues at edges 21, 52, 83; missed set at 80.
    @(negedge clk);
    rst2 = 1'b1;
    n_en = 0; bad = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (mon_en2) begin
        n_en++;
        if (!mon_tick2) bad++;
      end
      if (k == 79) chk("missed_before", 64'(missed2), 64'd0);
      if (k == 80) chk("missed_after", 64'(missed2), 64'd1);
    end
    chk("missed_issue_count", 64'(n_en), 64'd3);
    chk("missed_issue_is_tick", 64'(bad), 64'd0);
    chk("missed_sticky", 64'(missed2), 64'd1);
    $display("missed: issues=%0d missed_deadline=%0b", n_en, missed2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
